// File: rtl/flow_pkg.sv
// Shared widths and helpers for the egress flow blocks.
package flow_pkg;

    localparam int unsigned FLOW_DATA_WIDTH = 480;
    localparam int unsigned FLOW_CTRL_WIDTH = 32;
    localparam int unsigned DROP_CNT_WIDTH  = 16;

    typedef logic [1:0] qid_t;

    // Saturating add of up to four per-cycle drops into the drop counter.
    function automatic logic [DROP_CNT_WIDTH-1:0] drop_sat_add(
        input logic [DROP_CNT_WIDTH-1:0] cnt,
        input logic [2:0]                inc
    );
        logic [DROP_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_WIDTH-2){1'b0}}, inc};
        return sum[DROP_CNT_WIDTH] ? {DROP_CNT_WIDTH{1'b1}} : sum[DROP_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// Synchronous FIFO with registered occupancy count; callers must not push when full
// or pop when empty (requests are gated internally as a safety net).
module egress_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/egress_merge_q.sv
// Four-input round-robin merge into one registered output with per-input FIFOs.
// Define EGRESS_MERGE_DROP_CNT_EN to build the saturating drop counter.
module egress_merge_q
    import flow_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLOW_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = FLOW_CTRL_WIDTH,
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_wr_0,
    input  logic                      in_wr_1,
    input  logic                      in_wr_2,
    input  logic                      in_wr_3,
    input  logic [CTRL_WIDTH-1:0]     in_ctl_0,
    input  logic [CTRL_WIDTH-1:0]     in_ctl_1,
    input  logic [CTRL_WIDTH-1:0]     in_ctl_2,
    input  logic [CTRL_WIDTH-1:0]     in_ctl_3,
    input  logic [DATA_WIDTH-1:0]     in_data_0,
    input  logic [DATA_WIDTH-1:0]     in_data_1,
    input  logic [DATA_WIDTH-1:0]     in_data_2,
    input  logic [DATA_WIDTH-1:0]     in_data_3,
    output logic                      out_wr,
    output logic [CTRL_WIDTH-1:0]     out_ctl,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      out_rdy,
    output logic [3:0]                fifo_full,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_QUEUES-1:0] w_in_wr;
    logic [WORD_W-1:0]     w_in_word [NUM_QUEUES];
    logic [WORD_W-1:0]     w_rdata   [NUM_QUEUES];
    logic [CNT_W-1:0]      w_count   [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] w_full;
    logic [NUM_QUEUES-1:0] w_empty;
    logic [NUM_QUEUES-1:0] w_push;
    logic [NUM_QUEUES-1:0] w_pop;
    logic                  w_load;
    logic                  w_grant_vld;
    qid_t                  w_grant_idx;

    logic                  r_out_wr;
    logic [WORD_W-1:0]     r_out_word;
    qid_t                  r_last_grant;

    assign w_in_wr      = {in_wr_3, in_wr_2, in_wr_1, in_wr_0};
    assign w_in_word[0] = {in_ctl_0, in_data_0};
    assign w_in_word[1] = {in_ctl_1, in_data_1};
    assign w_in_word[2] = {in_ctl_2, in_data_2};
    assign w_in_word[3] = {in_ctl_3, in_data_3};

    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign w_push = w_in_wr & ~w_full;

    for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_fifo
        egress_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[k]),
            .i_pop   (w_pop[k]),
            .i_wdata (w_in_word[k]),
            .o_rdata (w_rdata[k]),
            .o_count (w_count[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
        assign fifo_full[k] = (w_count[k] == CNT_W'(FIFO_DEPTH));
    end

    assign w_load = !r_out_wr || out_rdy;

    always_comb begin
        qid_t v_idx;
        v_idx       = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = r_last_grant;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last_grant + 2'(i);
            if (!w_grant_vld && !w_empty[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        if (w_load && w_grant_vld) w_pop[w_grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wr     <= 1'b0;
            r_out_word   <= '0;
            r_last_grant <= 2'd3;
        end else if (w_load) begin
            r_out_wr <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_word   <= w_rdata[w_grant_idx];
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign out_wr   = r_out_wr;
    assign out_ctl  = r_out_word[WORD_W-1 -: CTRL_WIDTH];
    assign out_data = r_out_word[DATA_WIDTH-1:0];

`ifdef EGRESS_MERGE_DROP_CNT_EN
    logic [NUM_QUEUES-1:0]     w_drop;
    logic [2:0]                w_drop_num;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    assign w_drop     = w_in_wr & w_full;
    assign w_drop_num = 3'($countones(w_drop));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_drop_cnt <= '0;
        else      r_drop_cnt <= drop_sat_add(r_drop_cnt, w_drop_num);
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_egress_merge_q.sv
// Directed bench for egress_merge_q: latency, round-robin order, backpressure,
// overflow drops, reset flush and drop-counter saturation.
module tb_egress_merge_q;

    localparam int DW = 480;
    localparam int CW = 32;
`ifdef EGRESS_MERGE_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_wr_0 = 0, in_wr_1 = 0, in_wr_2 = 0, in_wr_3 = 0;
    logic [CW-1:0] in_ctl_0 = '0, in_ctl_1 = '0, in_ctl_2 = '0, in_ctl_3 = '0;
    logic [DW-1:0] in_data_0 = '0, in_data_1 = '0, in_data_2 = '0, in_data_3 = '0;
    logic          out_wr;
    logic [CW-1:0] out_ctl;
    logic [DW-1:0] out_data;
    logic          out_rdy = 1'b0;
    logic [3:0]    fifo_full;
    logic [15:0]   drop_cnt;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    egress_merge_q dut (
        .clk       (clk),
        .rst       (rst),
        .in_wr_0   (in_wr_0),
        .in_wr_1   (in_wr_1),
        .in_wr_2   (in_wr_2),
        .in_wr_3   (in_wr_3),
        .in_ctl_0  (in_ctl_0),
        .in_ctl_1  (in_ctl_1),
        .in_ctl_2  (in_ctl_2),
        .in_ctl_3  (in_ctl_3),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .out_wr    (out_wr),
        .out_ctl   (out_ctl),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_wr_0 = 0; in_wr_1 = 0; in_wr_2 = 0; in_wr_3 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        rst = 1'b0;
        #2;
        check("rst_out_wr", 512'(out_wr), 512'(0));
        check("rst_fifo_full", 512'(fifo_full), 512'(0));
        check("rst_drop_cnt", 512'(drop_cnt), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single push on input 2, one-cycle latency
        out_rdy = 1'b1;
        in_wr_2 = 1; in_data_2 = DW'(8'hA5); in_ctl_2 = CW'(2);
        step();
        clear_inputs();
        check("lat_before", 512'(out_wr), 512'(0));
        step();
        check("lat_out_wr", 512'(out_wr), 512'(1));
        check("lat_out_data", 512'(out_data), 512'(8'hA5));
        check("lat_out_ctl", 512'(out_ctl), 512'(2));
        step();
        check("lat_after", 512'(out_wr), 512'(0));

        // All four push in one cycle: order 0,1,2,3
        do_reset();
        out_rdy = 1'b1;
        in_wr_0 = 1; in_data_0 = DW'(32'h10);
        in_wr_1 = 1; in_data_1 = DW'(32'h11);
        in_wr_2 = 1; in_data_2 = DW'(32'h12);
        in_wr_3 = 1; in_data_3 = DW'(32'h13);
        step();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr4_wr", 512'(out_wr), 512'(1));
            check("rr4_data", 512'(out_data), 512'(32'h10 + k));
        end
        step();
        check("rr4_idle", 512'(out_wr), 512'(0));

        // Backpressure fill of input 0 with one overflow drop
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_wr_0 = 1; in_data_0 = DW'(32'h30 + i);
            step();
        end
        clear_inputs();
        check("fill_out_wr", 512'(out_wr), 512'(1));
        check("fill_out_data", 512'(out_data), 512'(32'h30));
        check("fill_full", 512'(fifo_full), 512'(4'b0001));
        check("fill_drop", 512'(drop_cnt), 512'(DROP_EN ? 1 : 0));
        step();
        check("fill_stall_data", 512'(out_data), 512'(32'h30));
        out_rdy = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("drain_data", 512'(out_data), 512'(32'h30 + j));
            if (j == 1) check("drain_full_clr", 512'(fifo_full), 512'(0));
        end
        step();
        check("drain_idle", 512'(out_wr), 512'(0));

        // out_rdy toggling with continuous pushes on inputs 1 and 3
        do_reset();
        n = 0;
        for (int c = 0; c < 16; c++) begin
            in_wr_1 = 1; in_data_1 = DW'(32'h100 + c);
            in_wr_3 = 1; in_data_3 = DW'(32'h300 + c);
            out_rdy = (c % 2 == 0);
            if (out_wr && out_rdy) begin
                check("alt_word", 512'(out_data),
                      512'(((n % 2 == 0) ? 32'h100 : 32'h300) + 32'(n / 2)));
                n++;
            end
            step();
        end
        clear_inputs();
        check("alt_count", 512'(n), 512'(7));

        // Reset mid-operation with 3 words buffered and output valid
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_wr_0 = 1; in_data_0 = DW'(32'h50 + i);
            step();
        end
        clear_inputs();
        check("midrst_pre_wr", 512'(out_wr), 512'(1));
        rst = 1'b0;
        #2;
        check("midrst_out_wr", 512'(out_wr), 512'(0));
        check("midrst_full", 512'(fifo_full), 512'(0));
        check("midrst_drop", 512'(drop_cnt), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_out", 512'(out_wr), 512'(0));
        end

        // Drop counter: saturation when built in, constant zero otherwise
        do_reset();
        out_rdy = 1'b0;
        in_wr_0 = 1; in_wr_1 = 1; in_wr_2 = 1; in_wr_3 = 1;
        if (DROP_EN) begin
            for (int i = 0; i < 5 + 16382; i++) step();
            check("drop_near_max", 512'(drop_cnt), 512'(16'hFFFB));
            step();
            check("drop_reach_max", 512'(drop_cnt), 512'(16'hFFFF));
            step();
            check("drop_saturated", 512'(drop_cnt), 512'(16'hFFFF));
        end else begin
            for (int i = 0; i < 10; i++) step();
            check("drop_disabled", 512'(drop_cnt), 512'(0));
        end
        clear_inputs();
        check("drop_full_all", 512'(fifo_full), 512'(4'b1111));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/egress_merge_q.md
EGRESS_MERGE_Q -- requirements
Module: egress_merge_q

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 480, data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 32, control word width.
REQ-003 SHALL have parameter NUM_QUEUES, default 4, number of merged inputs (fixed at 4 in this revision).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, words per input FIFO, power of two, >=2.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports in_wr_0..in_wr_3  input  1 each  input word valid; no backpressure upstream.
REQ-008 SHALL have ports in_ctl_0..in_ctl_3  input  CTRL_WIDTH each  control word for input k.
REQ-009 SHALL have ports in_data_0..in_data_3  input  DATA_WIDTH each  data word for input k.
REQ-010 SHALL have port out_wr  output  1  output valid.
REQ-011 SHALL have port out_ctl  output  CTRL_WIDTH  output control word.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  output data word.
REQ-013 SHALL have port out_rdy  input  1  downstream ready.
REQ-014 SHALL have port fifo_full  output  4  per-input FIFO full flags (registered count == FIFO_DEPTH).
REQ-015 SHALL have port drop_cnt  output  16  total words dropped, saturating.

Function
REQ-016 SHALL push {in_ctl_k,in_data_k} into FIFO k on a cycle with in_wr_k=1 and fifo_full[k]=0.
REQ-017 SHALL drop the word when in_wr_k=1 and fifo_full[k]=1, even if FIFO k pops in the same cycle.
REQ-018 SHALL hold out_wr/out_ctl/out_data in a single output register; transfer occurs on out_wr=1 and out_rdy=1.
REQ-019 SHALL keep out_ctl/out_data stable while out_wr=1 and out_rdy=0.
REQ-020 SHALL pop one FIFO per cycle when output register empty or transferring, loading the output register same edge.
REQ-021 SHALL select the pop source round-robin among non-empty FIFOs, searching from (last_grant+1) mod 4.
REQ-022 SHALL update last_grant only on a pop; reset value 3 (first search starts at input 0).
REQ-023 SHALL give minimum latency 1 cycle: word written at edge N, out_wr=1 after edge N+1 when FIFO and output register empty.
REQ-024 SHALL allow simultaneous push and pop on a non-full FIFO with count unchanged.
REQ-025 SHALL sustain one word per cycle with out_rdy held 1.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-027 SHALL increment drop_cnt by the number of inputs dropping in that cycle (0..4), saturating at 0xFFFF.

Reset
REQ-028 SHALL on rst=0 asynchronously clear out_wr, out_ctl, out_data, all FIFO pointers/counts, fifo_full, drop_cnt, and set last_grant=3.
REQ-029 SHALL discard all buffered words on reset mid-operation; no word emitted after reset deasserts until a new push.

Configuration
REQ-030 SHALL with macro EGRESS_MERGE_DROP_CNT_EN defined implement drop_cnt per REQ-027.
REQ-031 SHALL without EGRESS_MERGE_DROP_CNT_EN tie drop_cnt to 0 with no counter logic; drop behaviour otherwise identical.

Structure
REQ-032 SHALL take DATA_WIDTH/CTRL_WIDTH defaults and the drop counter width from shared package flow_pkg.
REQ-033 SHALL instantiate four copies of sub-module egress_fifo (synchronous FIFO, count/full/empty outputs, async active-low reset).

Verification
REQ-034 SHALL verify: single push on input 2 (data=0xA5), out_rdy=1 -> out_wr=1 one cycle later with out_data=0xA5, then 0.
REQ-035 SHALL verify: all four inputs push one word same cycle, out_rdy=1 -> outputs in order 0,1,2,3 on consecutive cycles.
REQ-036 SHALL verify: out_rdy=0, 6 consecutive pushes on input 0 (FIFO_DEPTH=4) -> 1 word in output register, 4 buffered, fifo_full[0]=1, drop_cnt=1.
REQ-037 SHALL verify: out_rdy toggling 1/0 every cycle with continuous pushes on inputs 1 and 3 -> alternating 1,3 grants, no word duplicated or reordered per input.
REQ-038 SHALL verify: rst asserted with 3 words buffered and out_wr=1 -> out_wr=0 immediately, fifo_full=0, drop_cnt=0, no output after release.
REQ-039 SHALL verify: drop_cnt preset near 0xFFFE, four-input drop cycle -> drop_cnt=0xFFFF; build without EGRESS_MERGE_DROP_CNT_EN -> drop_cnt stays 0.
